// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - funct3 access-size encodings (loads, with store aliases)
//   - arbiter FSM state enum
//   - grant selector enum
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = F3_LB;
  localparam logic [2:0] F3_SH  = F3_LH;
  localparam logic [2:0] F3_SW  = F3_LW;

  typedef enum logic {
    S_CPU_PRI   = 1'b0,
    S_DMA_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } gnt_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU, DMA and data_mem signals of the arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, data, mem_* out)
//   master : environment view (CPU, DMA and data_mem side)
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // CPU (MEM stage) port
  logic                  cpu_req;
  logic                  cpu_we;
  logic [2:0]            cpu_funct3;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_stall;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  // DMA / loader port
  logic                  dma_req;
  logic                  dma_we;
  logic [2:0]            dma_funct3;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_WIDTH-1:0] dma_rdata;
  // data_mem side
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req, dma_we, dma_funct3, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_wr_en, mem_funct3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req, dma_we, dma_funct3, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_wr_en, mem_funct3, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: saturating count of consecutive denied DMA cycles.
//   clk, rst_n   : clock, synchronous active-low reset
//   inc_i        : DMA requesting but not granted this cycle
//   clr_i        : DMA granted or not requesting (wins over inc_i)
//   cnt_o        : current count
//   limit_hit_o  : the count being loaded at the next edge equals LIMIT
module dmem_starve_ctr #(
  parameter int LIMIT = 4,
  localparam int W    = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         limit_hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Looking at the next value lets the FSM enter the forced state on the
  // same edge the counter reaches the limit.
  assign limit_hit_o = (cnt_d == W'(LIMIT));
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data_mem between the CPU MEM stage and
// a DMA/loader port. CPU has fixed priority; after STARVE_LIMIT consecutive
// denials the DMA gets one forced grant while the CPU is stalled.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem_arbiter_if.slave (CPU port, DMA port, data_mem port)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state_q, state_d;
  gnt_t                  gnt;
  logic                  dma_gnt;
  logic                  dma_load;
  logic                  limit_hit;
  logic [CW-1:0]         starve_cnt;
  logic                  dma_rvalid_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  // Grant decode and data_mem mux
  always_comb begin
    gnt = GNT_NONE;
    case (state_q)
      S_CPU_PRI: begin
        if (bus.cpu_req)      gnt = GNT_CPU;
        else if (bus.dma_req) gnt = GNT_DMA;
      end
      S_DMA_FORCE: begin
        // DMA dropping its request here leaves the cycle idle.
        if (bus.dma_req) gnt = GNT_DMA;
      end
      default: gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    bus.mem_wr_en  = 1'b0;
    bus.mem_funct3 = F3_LW;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (gnt)
      GNT_CPU: begin
        bus.mem_wr_en  = bus.cpu_we;
        bus.mem_funct3 = bus.cpu_funct3;
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_wdata  = bus.cpu_wdata;
      end
      GNT_DMA: begin
        bus.mem_wr_en  = bus.dma_we;
        bus.mem_funct3 = bus.dma_funct3;
        bus.mem_addr   = bus.dma_addr;
        bus.mem_wdata  = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign dma_gnt       = (gnt == GNT_DMA);
  assign dma_load      = dma_gnt && !bus.dma_we;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = bus.cpu_req && (gnt != GNT_CPU);
  assign bus.cpu_rdata = bus.mem_rdata;

  dmem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (bus.dma_req && !dma_gnt),
    .clr_i       (dma_gnt || !bus.dma_req),
    .cnt_o       (starve_cnt),
    .limit_hit_o (limit_hit)
  );

  // Next-state: the forced state always lasts a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CPU_PRI:   if (limit_hit) state_d = S_DMA_FORCE;
      S_DMA_FORCE: state_d = S_CPU_PRI;
      default:     state_d = S_CPU_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_CPU_PRI;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dma_rvalid_q <= dma_load;
      if (dma_load) dma_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-addressed
// data_mem model (combinational read, store at posedge).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // data_mem model
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  logic [31:0] word;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always_comb begin
    a0 = bus.mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    word = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (bus.mem_funct3)
      F3_LB:   bus.mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      F3_LH:   bus.mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      F3_LBU:  bus.mem_rdata = {24'h0, mem[a0]};
      F3_LHU:  bus.mem_rdata = {16'h0, mem[a1], mem[a0]};
      default: bus.mem_rdata = word;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[a0] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) mem[a1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3[1:0] == 2'b10) begin
        mem[a2] <= bus.mem_wdata[23:16];
        mem[a3] <= bus.mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_funct3 = f3;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic dma_set(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.dma_req = req; bus.dma_we = we; bus.dma_funct3 = f3;
    bus.dma_addr = addr; bus.dma_wdata = wdata;
  endtask

  // drive point: just after the active edge; check point: opposite edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e;
    // Reset held 2 cycles with both requests high
    rst_n = 1'b0;
    cpu_set(1, 0, F3_LW, 32'h0, 32'h0);
    dma_set(1, 0, F3_LW, 32'h4, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mid();
    chk("rst_rvalid", bus.dma_rvalid, 0);
    chk("rst_rdata", bus.dma_rdata, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    $display("reset released: cpu granted first cycle");

    // Idle: no-grant defaults
    tick(); cpu_set(0, 0, F3_LB, 32'h0, 32'h0); dma_set(0, 0, F3_LB, 32'h0, 32'h0);
    mid();
    chk("idle_wr_en", bus.mem_wr_en, 0);
    chk("idle_funct3", bus.mem_funct3, 3'b010);
    chk("idle_addr", bus.mem_addr, 0);
    chk("idle_wdata", bus.mem_wdata, 0);
    chk("idle_dma_gnt", bus.dma_gnt, 0);
    $display("idle cycle: no grant");

    // CPU only
    tick(); cpu_set(1, 1, F3_SW, 32'h10, 32'hDEADBEEF);
    mid();
    chk("cpu_sw_stall", bus.cpu_stall, 0);
    chk("cpu_sw_wr_en", bus.mem_wr_en, 1);
    chk("cpu_sw_addr", bus.mem_addr, 32'h10);
    chk("cpu_sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    $display("cpu sw 0xDEADBEEF -> 0x10");
    tick(); cpu_set(1, 0, F3_LW, 32'h10, 32'h0);
    mid();
    chk("cpu_lw_stall", bus.cpu_stall, 0);
    chk("cpu_lw_wr_en", bus.mem_wr_en, 0);
    chk("cpu_lw_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    $display("cpu lw 0x10 -> %h", bus.cpu_rdata);
    tick(); cpu_set(1, 1, F3_SB, 32'h11, 32'h000000AA);
    mid();
    chk("cpu_sb_stall", bus.cpu_stall, 0);
    chk("cpu_sb_funct3", bus.mem_funct3, 3'b000);
    $display("cpu sb 0xAA -> 0x11");
    tick(); cpu_set(1, 0, F3_LBU, 32'h11, 32'h0);
    mid();
    chk("cpu_lbu_rdata", bus.cpu_rdata, 32'h000000AA);
    $display("cpu lbu 0x11 -> %h", bus.cpu_rdata);
    tick(); cpu_set(1, 0, F3_LW, 32'h10, 32'h0);
    mid();
    chk("cpu_lw2_rdata", bus.cpu_rdata, 32'hDEADAAEF);
    $display("cpu lw 0x10 -> %h", bus.cpu_rdata);

    // DMA only
    tick(); cpu_set(0, 0, F3_LW, 32'h0, 32'h0); dma_set(1, 1, F3_SW, 32'h20, 32'h12345678);
    mid();
    chk("dma_sw_gnt", bus.dma_gnt, 1);
    chk("dma_sw_wr_en", bus.mem_wr_en, 1);
    chk("dma_sw_addr", bus.mem_addr, 32'h20);
    chk("dma_sw_cpu_stall", bus.cpu_stall, 0);
    $display("dma sw 0x12345678 -> 0x20");
    tick(); dma_set(1, 0, F3_LW, 32'h20, 32'h0);
    mid();
    chk("dma_lw_gnt", bus.dma_gnt, 1);
    chk("dma_lw_wr_en", bus.mem_wr_en, 0);
    chk("dma_sw_no_rvalid", bus.dma_rvalid, 0);
    $display("dma lw 0x20 granted");
    tick(); dma_set(0, 0, F3_LW, 32'h0, 32'h0);
    mid();
    chk("dma_lw_rvalid", bus.dma_rvalid, 1);
    chk("dma_lw_rdata", bus.dma_rdata, 32'h12345678);
    $display("dma rvalid rdata=%h", bus.dma_rdata);
    tick();
    mid();
    chk("dma_rvalid_once", bus.dma_rvalid, 0);
    $display("dma rvalid dropped");

    // Contention: DMA forced every 5th cycle
    tick(); cpu_set(1, 0, F3_LW, 32'h10, 32'h0); dma_set(1, 0, F3_LW, 32'h20, 32'h0);
    for (int c = 1; c <= 11; c++) begin
      mid();
      e = (c % 5 == 0);
      chk($sformatf("cont_gnt_c%0d", c), bus.dma_gnt, e);
      chk($sformatf("cont_stall_c%0d", c), bus.cpu_stall, e);
      chk($sformatf("cont_addr_c%0d", c), bus.mem_addr, e ? 32'h20 : 32'h10);
      chk($sformatf("cont_rvalid_c%0d", c), bus.dma_rvalid, (c % 5 == 1) && (c > 1));
      if (c == 6) chk("cont_rdata", bus.dma_rdata, 32'h12345678);
      $display("contention cycle %0d: dma_gnt=%0b cpu_stall=%0b", c, bus.dma_gnt, bus.cpu_stall);
      tick();
    end
    cpu_set(0, 0, F3_LW, 32'h0, 32'h0); dma_set(0, 0, F3_LW, 32'h0, 32'h0);

    // DMA withdraws after 3 denials; counter must restart
    tick(); cpu_set(1, 0, F3_LW, 32'h10, 32'h0); dma_set(1, 0, F3_LW, 32'h24, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      mid();
      chk($sformatf("wd_denied_c%0d", c), bus.dma_gnt, 0);
      $display("withdraw cycle %0d: dma denied", c);
      tick();
    end
    dma_set(0, 0, F3_LW, 32'h0, 32'h0);
    mid();
    chk("wd_dropped_gnt", bus.dma_gnt, 0);
    $display("withdraw: dma_req dropped");
    tick(); dma_set(1, 0, F3_LW, 32'h20, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      mid();
      chk($sformatf("wd_again_gnt_c%0d", c), bus.dma_gnt, c == 5);
      chk($sformatf("wd_again_stall_c%0d", c), bus.cpu_stall, c == 5);
      $display("re-request cycle %0d: dma_gnt=%0b", c, bus.dma_gnt);
      tick();
    end
    cpu_set(0, 0, F3_LW, 32'h0, 32'h0); dma_set(0, 0, F3_LW, 32'h0, 32'h0);

    // Reset while a forced DMA read is pending
    tick(); cpu_set(1, 0, F3_LW, 32'h10, 32'h0); dma_set(1, 0, F3_LW, 32'h20, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      mid(); tick();
    end
    rst_n = 1'b0;
    mid();
    chk("rstrd_c4_gnt", bus.dma_gnt, 0);
    $display("reset asserted with forced dma read pending");
    tick(); rst_n = 1'b1;
    mid();
    chk("rstrd_gnt", bus.dma_gnt, 0);
    chk("rstrd_stall", bus.cpu_stall, 0);
    chk("rstrd_rvalid", bus.dma_rvalid, 0);
    tick(); cpu_set(0, 0, F3_LW, 32'h0, 32'h0); dma_set(0, 0, F3_LW, 32'h0, 32'h0);
    mid();
    chk("rstrd_rvalid2", bus.dma_rvalid, 0);
    $display("after reset: forced grant discarded, no rvalid");

    // Reset while a forced DMA store is pending
    tick(); cpu_set(1, 0, F3_LW, 32'h10, 32'h0); dma_set(1, 1, F3_SW, 32'h30, 32'hCAFEF00D);
    for (int c = 1; c <= 3; c++) begin
      mid(); tick();
    end
    rst_n = 1'b0;
    mid();
    tick(); rst_n = 1'b1;
    mid();
    chk("rstwr_gnt", bus.dma_gnt, 0);
    chk("rstwr_stall", bus.cpu_stall, 0);
    tick(); cpu_set(1, 0, F3_LW, 32'h30, 32'h0); dma_set(0, 0, F3_LW, 32'h0, 32'h0);
    mid();
    chk("rstwr_mem", bus.cpu_rdata, 32'h0);
    $display("after reset: aborted store left 0x30 = %h", bus.cpu_rdata);
    tick(); cpu_set(1, 0, F3_LW, 32'h20, 32'h0);
    mid();
    chk("rstwr_mem20", bus.cpu_rdata, 32'h12345678);
    $display("0x20 still %h", bus.cpu_rdata);

    tick(); cpu_set(0, 0, F3_LW, 32'h0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port `data_mem` between the pipeline MEM stage (CPU port) and a DMA/loader port. Each cycle it grants at most one requester and drives `data_mem`'s write-enable, funct3, address and write-data. It returns read data combinationally to the CPU and registered to DMA. Fixed priority favours the CPU; a starvation counter forces a DMA grant after a bounded number of denials, and the CPU is stalled for that cycle.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports
- `DATA_WIDTH`, 32, data width on all ports
- `STARVE_LIMIT`, 4, consecutive denied DMA cycles before a DMA grant is forced (≥1)
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset; synchronous, active-low
- `cpu_req`  in  1  MEM stage performs a load/store this cycle
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_funct3`  in  3  access size/sign (sb/sh/sw, lb/lh/lw/lbu/lhu encodings)
- `cpu_addr`  in  ADDR_WIDTH  byte address
- `cpu_wdata`  in  DATA_WIDTH  store data
- `cpu_stall`  out  1  CPU request not served this cycle; pipeline must hold
- `cpu_rdata`  out  DATA_WIDTH  load data; valid when `cpu_req && !cpu_stall`
- `dma_req`, `dma_we`, `dma_funct3`, `dma_addr`, `dma_wdata`  in  1/1/3/ADDR_WIDTH/DATA_WIDTH  DMA request fields; same meaning as the CPU fields
- `dma_gnt`  out  1  DMA request served this cycle
- `dma_rvalid`  out  1  registered DMA load data valid
- `dma_rdata`  out  DATA_WIDTH  registered DMA load data
- `mem_wr_en`  out  1  to `data_mem` `wr_en`
- `mem_funct3`  out  3  to `data_mem` `funct3`
- `mem_addr`  out  ADDR_WIDTH  to `data_mem` `wr_addr`
- `mem_wdata`  out  DATA_WIDTH  to `data_mem` `wr_data`
- `mem_rdata`  in  DATA_WIDTH  from `data_mem` `rd_data_mem` (combinational)

## Operation
- States: `S_CPU_PRI` (normal) and `S_DMA_FORCE`.
- In `S_CPU_PRI`, the grant goes to the CPU if `cpu_req`, otherwise to DMA if `dma_req`, otherwise to nobody.
- In `S_DMA_FORCE`, the grant goes to DMA. `cpu_stall = cpu_req`.
- Starvation counter `starve_cnt`, width `$clog2(STARVE_LIMIT+1)`:
  - +1 when `dma_req && !dma_gnt`.
  - Cleared when `dma_gnt`, or when `!dma_req`.
  - Saturates at `STARVE_LIMIT`.
- Transition `S_CPU_PRI` → `S_DMA_FORCE` when the next `starve_cnt == STARVE_LIMIT`.
- Transition `S_DMA_FORCE` → `S_CPU_PRI` after one cycle, or immediately if `dma_req` dropped (no grant in that case).
- Mux: the granted requester's fields drive the `mem_*` outputs, and `mem_wr_en = granted_we`.
- With no grant: `mem_wr_en=0`, `mem_funct3=3'b010`, `mem_addr=0`, `mem_wdata=0`.
- `cpu_rdata = mem_rdata` unconditionally. Its value is meaningful only on a served CPU load.
- DMA load grant: capture `mem_rdata` into `dma_rdata` at the clock edge, and assert `dma_rvalid` for exactly the next cycle.
- DMA store grant: `dma_rvalid` stays 0.
- DMA must hold its request fields stable until `dma_gnt`. The CPU holds its fields while `cpu_stall`.
- funct3 and address are passed through unmodified. Alignment and size handling belong to `data_mem`.

## Timing
- Reset (`rst_n=0` at a posedge):
  - State → `S_CPU_PRI`, `starve_cnt=0`, `dma_rvalid=0`, `dma_rdata=0`.
  - Combinational outputs follow from the reset state.
- Reset mid-operation discards any pending forced grant. A DMA read granted in the reset cycle produces no `dma_rvalid`.
- Outputs with zero-cycle latency (combinational from inputs and state): `cpu_stall`, `dma_gnt`, the `mem_*` outputs, `cpu_rdata`.
- Stores take effect at the posedge ending the grant cycle.
- DMA read latency is 1 cycle (grant cycle N → `dma_rvalid` in N+1).
- Simultaneous `cpu_req` and `dma_req` in `S_CPU_PRI` with `starve_cnt < STARVE_LIMIT`: CPU wins and `starve_cnt` increments.
- Worst-case DMA wait under continuous CPU traffic is `STARVE_LIMIT` cycles. The grant occurs on cycle `STARVE_LIMIT+1`.
- Back-to-back forced grants are impossible: the counter restarts from 0 after each grant.

## Structure
- Shared package `dmem_pkg`:
  - funct3 constants: `F3_LB=000`, `F3_LH=001`, `F3_LW=010`, `F3_LBU=100`, `F3_LHU=101`, with SB/SH/SW aliases.
  - State enum `arb_state_t`.
  - Grant enum `{GNT_NONE, GNT_CPU, GNT_DMA}`.
- One sub-module, `dmem_starve_ctr`: the saturating counter with `inc`/`clr` inputs and a `limit_hit` output.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with both requests high → after release, `dma_rvalid=0`, state `S_CPU_PRI`; first cycle CPU granted, `cpu_stall=0`.
- CPU only: sw `0xDEADBEEF` to `0x10`, then lw `0x10` → `cpu_stall` always 0, `cpu_rdata=0xDEADBEEF`; sb `0xAA` to `0x11` then lbu `0x11` → `0x000000AA`.
- DMA only: DMA sw `0x12345678` to `0x20`, then lw `0x20` → `dma_gnt=1` both cycles; `dma_rvalid=1` with `dma_rdata=0x12345678` one cycle after the read grant.
- Contention with `STARVE_LIMIT=4`: CPU and DMA request continuously → CPU served cycles 1-4, DMA granted cycle 5 with `cpu_stall=1`, CPU served cycle 6; pattern repeats every 5 cycles.
- DMA withdraws: DMA requests for 3 denied cycles, then drops `dma_req` → `starve_cnt` returns to 0; the next DMA request waits a full 4 cycles again.
- Reset while `S_DMA_FORCE` is pending with a DMA read → no `dma_rvalid` after reset; memory contents are unchanged for the aborted store variant.
